// File: rtl/idu_hazard_sb.sv
// rtl/idu_hazard_sb.sv - IDU issue scoreboard for long-latency instruction hazards
//
// Purpose: tracks up to SB_DEPTH outstanding long-latency instructions (mul/div/load).
// Each entry holds {valid, rd_we, rd}, and its index is the instruction ID. Decoded
// instructions are stalled on RAW, WAW or structural (table full) hazards.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   issue_*_i                decoded instruction: valid, long flag, rd/rs1/rs2 and their enables
//   commit_valid_i/_id_i     a long instruction with this ID completed
//   flush_i                  drop every outstanding entry
//   issue_ready_o            instruction may advance (combinational, does not look at issue_valid_i)
//   issue_id_o               ID that an accepted long instruction receives
//   hold_o                   stall request to ctrl
//   sb_full_o, sb_empty_o    registered occupancy flags
//   outstanding_cnt_o        registered count of valid entries
//   commit_err_o             sticky flag: a commit named an entry that was not valid
module idu_hazard_sb #(
  parameter int SB_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid_i,
  input  logic       issue_long_i,
  input  logic       issue_rd_we_i,
  input  logic [4:0] issue_rd_i,
  input  logic       issue_rs1_re_i,
  input  logic [4:0] issue_rs1_i,
  input  logic       issue_rs2_re_i,
  input  logic [4:0] issue_rs2_i,
  input  logic       commit_valid_i,
  input  logic [1:0] commit_id_i,
  input  logic       flush_i,
  output logic       issue_ready_o,
  output logic [1:0] issue_id_o,
  output logic       hold_o,
  output logic       sb_full_o,
  output logic       sb_empty_o,
  output logic [2:0] outstanding_cnt_o,
  output logic       commit_err_o
);

  logic [SB_DEPTH-1:0] valid_q, valid_d;
  logic [SB_DEPTH-1:0] rd_we_q, rd_we_d;
  logic [4:0]          rd_q [SB_DEPTH];
  logic [4:0]          rd_d [SB_DEPTH];
  logic [2:0]          cnt_q, cnt_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                err_q, err_d;

  logic       raw_haz, waw_haz, struct_haz;
  logic       free_found;
  logic [1:0] alloc_id;
  logic       alloc;
  logic       commit_hit;
  int         cnt_int;

  // Hazard detection looks only at registered table state, so a commit
  // releases its hazard one cycle after commit_valid_i.
  always_comb begin
    raw_haz = 1'b0;
    waw_haz = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (valid_q[i] && rd_we_q[i]) begin
        if (issue_rs1_re_i && (issue_rs1_i != 5'd0) && (issue_rs1_i == rd_q[i])) raw_haz = 1'b1;
        if (issue_rs2_re_i && (issue_rs2_i != 5'd0) && (issue_rs2_i == rd_q[i])) raw_haz = 1'b1;
        if (issue_rd_we_i  && (issue_rd_i  != 5'd0) && (issue_rd_i  == rd_q[i])) waw_haz = 1'b1;
      end
    end
    struct_haz    = issue_long_i && full_q;
    issue_ready_o = !rst && !flush_i && !raw_haz && !waw_haz && !struct_haz;
    hold_o        = issue_valid_i && !issue_ready_o;
  end

  // Lowest-index free entry; 0 when the table is full.
  always_comb begin
    free_found = 1'b0;
    alloc_id   = 2'd0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        alloc_id   = 2'(i);
        free_found = 1'b1;
      end
    end
    issue_id_o = alloc_id;
  end

  assign alloc = issue_valid_i && issue_ready_o && issue_long_i;

  always_comb begin
    valid_d    = valid_q;
    rd_we_d    = rd_we_q;
    rd_d       = rd_q;
    err_d      = err_q;
    commit_hit = 1'b0;

    for (int i = 0; i < SB_DEPTH; i++) begin
      if (commit_valid_i && (int'(commit_id_i) == i) && valid_q[i]) begin
        valid_d[i] = 1'b0;
        commit_hit = 1'b1;
      end
    end
    if (commit_valid_i && !commit_hit) err_d = 1'b1;

    // alloc_id is always a currently-free entry, so it never collides with
    // a same-cycle commit (which must target a valid entry to take effect).
    if (alloc) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (int'(alloc_id) == i) begin
          valid_d[i] = 1'b1;
          rd_we_d[i] = issue_rd_we_i;
          rd_d[i]    = issue_rd_i;
        end
      end
    end

    if (flush_i) valid_d = '0;

    cnt_int = 0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (valid_d[i]) cnt_int = cnt_int + 1;
    end
    cnt_d   = 3'(cnt_int);
    full_d  = (cnt_int == SB_DEPTH);
    empty_d = (cnt_int == 0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      rd_we_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) rd_q[i] <= 5'd0;
      cnt_q   <= 3'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd_we_q <= rd_we_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign sb_full_o         = full_q;
  assign sb_empty_o        = empty_q;
  assign outstanding_cnt_o = cnt_q;
  assign commit_err_o      = err_q;

endmodule
